// File: rtl/cpu_pipe_pkg.sv
// Shared encodings for the MCS8 pipeline sequencer: FSM states, PC source codes
// and the valid bit loaded into a stage register to form a NOP.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_HALTED   = 2'd3
  } pipe_state_t;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_INT = 2'd2;

  localparam logic STAGE_NOP_VLD = 1'b0;

endpackage

// File: rtl/cpu_perf_sat_cnt.sv
// Saturating up-counter for pipeline performance statistics; holds at all-ones.
module cpu_perf_sat_cnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// Central sequencer for the 5-stage MCS8 pipeline: merges data, branch, memory and
// halt/interrupt hazards into per-stage stall/flush/bubble enables and the PC select.
module cpu_pipe_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 16
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              BUBBLE_DATA_I,
  input  logic              BRANCH_TAKEN_I,
  input  logic              MEM_REQ_I,
  input  logic              MEM_ACK_I,
  input  logic              HALT_I,
  input  logic              INT_REQ_I,
  output logic              F_STALL_O,
  output logic              D_STALL_O,
  output logic              E_BUBBLE_O,
  output logic              D_FLUSH_O,
  output logic              M_STALL_O,
  output logic              W_BUBBLE_O,
  output logic [1:0]        PC_SEL_O,
  output logic              HALTED_O,
  output logic [PERF_W-1:0] STALL_CNT_O,
  output logic [PERF_W-1:0] FLUSH_CNT_O
);

  localparam logic [2:0] LP_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam pipe_state_t LP_AFTER_REDIRECT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  pipe_state_t r_state;
  pipe_state_t w_state_nxt;
  logic [2:0]  r_flush_cnt;
  logic [2:0]  w_flush_cnt_nxt;

  logic       w_mem_stall;
  logic       w_f_stall;
  logic       w_d_stall;
  logic       w_e_bubble;
  logic       w_d_flush;
  logic       w_m_stall;
  logic       w_w_bubble;
  logic [1:0] w_pc_sel;
  logic       w_halted;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_mem_stall     = MEM_REQ_I & ~MEM_ACK_I;
    w_f_stall       = 1'b0;
    w_d_stall       = 1'b0;
    w_e_bubble      = 1'b0;
    w_d_flush       = 1'b0;
    w_m_stall       = 1'b0;
    w_w_bubble      = 1'b0;
    w_pc_sel        = PC_SEQ;
    w_halted        = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          // Freeze everything; an E-stage branch stays in E/M and is seen again after ACK.
          w_f_stall   = 1'b1;
          w_d_stall   = 1'b1;
          w_m_stall   = 1'b1;
          w_w_bubble  = 1'b1;
          w_state_nxt = ST_MEM_WAIT;
        end else if (HALT_I) begin
          w_d_flush   = 1'b1;
          w_e_bubble  = 1'b1;
          w_state_nxt = ST_HALTED;
        end else if (BRANCH_TAKEN_I || INT_REQ_I) begin
          w_pc_sel        = BRANCH_TAKEN_I ? PC_BR : PC_INT;
          w_d_flush       = 1'b1;
          w_e_bubble      = 1'b1;
          w_flush_cnt_nxt = LP_FLUSH_LOAD;
          w_state_nxt     = LP_AFTER_REDIRECT;
        end else if (BUBBLE_DATA_I) begin
          w_f_stall  = 1'b1;
          w_d_stall  = 1'b1;
          w_e_bubble = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (!MEM_ACK_I) begin
          w_f_stall  = 1'b1;
          w_d_stall  = 1'b1;
          w_m_stall  = 1'b1;
          w_w_bubble = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_FLUSH: begin
        w_d_flush = 1'b1;
        if (w_mem_stall) begin
          w_f_stall  = 1'b1;
          w_d_stall  = 1'b1;
          w_m_stall  = 1'b1;
          w_w_bubble = 1'b1;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 3'd1;
          if (r_flush_cnt <= 3'd1) begin
            w_state_nxt = ST_RUN;
          end
        end
      end

      ST_HALTED: begin
        w_halted = 1'b1;
        if (INT_REQ_I) begin
          w_pc_sel        = PC_INT;
          w_d_flush       = 1'b1;
          w_e_bubble      = 1'b1;
          w_flush_cnt_nxt = LP_FLUSH_LOAD;
          w_state_nxt     = LP_AFTER_REDIRECT;
        end else begin
          w_f_stall  = 1'b1;
          w_e_bubble = 1'b1;
        end
      end

      default: w_state_nxt = ST_RUN;
    endcase

    // A flushed F/D register must never also be held.
    if (w_d_flush) begin
      w_d_stall = 1'b0;
    end

    if (RST_I) begin
      w_f_stall  = 1'b0;
      w_d_stall  = 1'b0;
      w_m_stall  = 1'b0;
      w_e_bubble = ~STAGE_NOP_VLD;
      w_d_flush  = 1'b1;
      w_w_bubble = ~STAGE_NOP_VLD;
      w_pc_sel   = PC_SEQ;
      w_halted   = 1'b0;
    end
  end

  assign F_STALL_O  = w_f_stall;
  assign D_STALL_O  = w_d_stall;
  assign E_BUBBLE_O = w_e_bubble;
  assign D_FLUSH_O  = w_d_flush;
  assign M_STALL_O  = w_m_stall;
  assign W_BUBBLE_O = w_w_bubble;
  assign PC_SEL_O   = w_pc_sel;
  assign HALTED_O   = w_halted;

  cpu_perf_sat_cnt #(.W(PERF_W)) u_stall_cnt (
    .i_clk (CLK_I),
    .i_rst (RST_I),
    .i_inc (w_f_stall | w_m_stall),
    .o_cnt (STALL_CNT_O)
  );

  cpu_perf_sat_cnt #(.W(PERF_W)) u_flush_cnt (
    .i_clk (CLK_I),
    .i_rst (RST_I),
    .i_inc (w_pc_sel != PC_SEQ),
    .o_cnt (FLUSH_CNT_O)
  );

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Directed bench for cpu_pipe_ctrl: a per-cycle vector table plus hand sequences
// for reset during a frozen flush and counter saturation.
module tb_cpu_pipe_ctrl;

  localparam int PW = 4;

  logic          clk;
  logic          rst, bub, br, mreq, mack, halt, intr;
  logic          f_stall, d_stall, e_bub, d_flush, m_stall, w_bub, halted;
  logic [1:0]    pc_sel;
  logic [PW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  cpu_pipe_ctrl #(.FLUSH_CYCLES(2), .PERF_W(PW)) u_dut (
    .CLK_I          (clk),
    .RST_I          (rst),
    .BUBBLE_DATA_I  (bub),
    .BRANCH_TAKEN_I (br),
    .MEM_REQ_I      (mreq),
    .MEM_ACK_I      (mack),
    .HALT_I         (halt),
    .INT_REQ_I      (intr),
    .F_STALL_O      (f_stall),
    .D_STALL_O      (d_stall),
    .E_BUBBLE_O     (e_bub),
    .D_FLUSH_O      (d_flush),
    .M_STALL_O      (m_stall),
    .W_BUBBLE_O     (w_bub),
    .PC_SEL_O       (pc_sel),
    .HALTED_O       (halted),
    .STALL_CNT_O    (stall_cnt),
    .FLUSH_CNT_O    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {rst, bub, br, mreq, mack, halt, intr}
  // out = {f_stall, d_stall, e_bub, d_flush, m_stall, w_bub, pc_sel[1:0], halted}
  typedef struct {
    logic [6:0] in;
    logic [8:0] out;
    logic [3:0] sc;
    logic [3:0] fc;
  } vec_t;

  localparam int NV = 37;
  vec_t tbl[NV];

  logic [8:0] outs;
  assign outs = {f_stall, d_stall, e_bub, d_flush, m_stall, w_bub, pc_sel, halted};

  task automatic drive(input logic [6:0] v);
    {rst, bub, br, mreq, mack, halt, intr} = v;
  endtask

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  // Drive on the falling edge, sample combinational outputs 1 ns later.
  task automatic step(input logic [6:0] v);
    @(negedge clk);
    drive(v);
    #1;
  endtask

  initial begin
    tbl[0]  = '{7'b1110000, 9'b001101000, 4'd0,  4'd0};
    tbl[1]  = '{7'b0000000, 9'b000000000, 4'd0,  4'd0};
    tbl[2]  = '{7'b0100000, 9'b111000000, 4'd0,  4'd0};
    tbl[3]  = '{7'b0100000, 9'b111000000, 4'd1,  4'd0};
    tbl[4]  = '{7'b0000000, 9'b000000000, 4'd2,  4'd0};
    tbl[5]  = '{7'b0010000, 9'b001100010, 4'd2,  4'd0};
    tbl[6]  = '{7'b0000000, 9'b000100000, 4'd2,  4'd1};
    tbl[7]  = '{7'b0000000, 9'b000000000, 4'd2,  4'd1};
    tbl[8]  = '{7'b0011000, 9'b110011000, 4'd2,  4'd1};
    tbl[9]  = '{7'b0011000, 9'b110011000, 4'd3,  4'd1};
    tbl[10] = '{7'b0011000, 9'b110011000, 4'd4,  4'd1};
    tbl[11] = '{7'b0011100, 9'b000000000, 4'd5,  4'd1};
    tbl[12] = '{7'b0010000, 9'b001100010, 4'd5,  4'd1};
    tbl[13] = '{7'b0000000, 9'b000100000, 4'd5,  4'd2};
    tbl[14] = '{7'b0000001, 9'b001100100, 4'd5,  4'd2};
    tbl[15] = '{7'b0001000, 9'b100111000, 4'd5,  4'd3};
    tbl[16] = '{7'b0000000, 9'b000100000, 4'd6,  4'd3};
    tbl[17] = '{7'b0000000, 9'b000000000, 4'd6,  4'd3};
    tbl[18] = '{7'b0000010, 9'b001100000, 4'd6,  4'd3};
    tbl[19] = '{7'b0000000, 9'b101000001, 4'd6,  4'd3};
    tbl[20] = '{7'b0000000, 9'b101000001, 4'd7,  4'd3};
    tbl[21] = '{7'b0000000, 9'b101000001, 4'd8,  4'd3};
    tbl[22] = '{7'b0000000, 9'b101000001, 4'd9,  4'd3};
    tbl[23] = '{7'b0000000, 9'b101000001, 4'd10, 4'd3};
    tbl[24] = '{7'b0000001, 9'b001100101, 4'd11, 4'd3};
    tbl[25] = '{7'b0000000, 9'b000100000, 4'd11, 4'd4};
    tbl[26] = '{7'b0000000, 9'b000000000, 4'd11, 4'd4};
    tbl[27] = '{7'b0001010, 9'b110011000, 4'd11, 4'd4};
    tbl[28] = '{7'b0001110, 9'b000000000, 4'd12, 4'd4};
    tbl[29] = '{7'b0110010, 9'b001100000, 4'd12, 4'd4};
    tbl[30] = '{7'b0110000, 9'b101000001, 4'd12, 4'd4};
    tbl[31] = '{7'b1000000, 9'b001101000, 4'd13, 4'd4};
    tbl[32] = '{7'b0000000, 9'b000000000, 4'd0,  4'd0};
    tbl[33] = '{7'b0010001, 9'b001100010, 4'd0,  4'd0};
    tbl[34] = '{7'b0000000, 9'b000100000, 4'd0,  4'd1};
    tbl[35] = '{7'b0100000, 9'b111000000, 4'd0,  4'd1};
    tbl[36] = '{7'b0000000, 9'b000000000, 4'd1,  4'd1};

    drive(7'b1000000);
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].in);
      chk("ctl", i, 16'(outs), 16'(tbl[i].out));
      chk("stall_cnt", i, 16'(stall_cnt), 16'(tbl[i].sc));
      chk("flush_cnt", i, 16'(flush_cnt), 16'(tbl[i].fc));
    end

    // Reset held for 3 cycles while frozen in FLUSH by a memory stall.
    step(7'b0010000);
    chk("rf_branch", 0, 16'(outs), 16'(9'b001100010));
    step(7'b0011000);
    chk("rf_frozen", 0, 16'(outs), 16'(9'b100111000));
    for (int i = 0; i < 3; i++) begin
      step(7'b1011000);
      chk("rf_rst_ctl", i, 16'(outs), 16'(9'b001101000));
      if (i > 0) begin
        chk("rf_rst_sc", i, 16'(stall_cnt), 16'd0);
        chk("rf_rst_fc", i, 16'(flush_cnt), 16'd0);
      end
    end
    step(7'b0000000);
    chk("rf_after_ctl", 0, 16'(outs), 16'd0);
    chk("rf_after_sc", 0, 16'(stall_cnt), 16'd0);
    chk("rf_after_fc", 0, 16'(flush_cnt), 16'd0);
    step(7'b0100000);
    chk("rf_run_bub", 0, 16'(outs), 16'(9'b111000000));

    // Saturation of the 4-bit stall counter over 20 stall cycles.
    step(7'b1000000);
    for (int i = 0; i < 20; i++) begin
      step(7'b0100000);
      if (i == 16) chk("sat_mid", i, 16'(stall_cnt), 16'd15);
    end
    step(7'b0000000);
    chk("sat_end", 0, 16'(stall_cnt), 16'd15);
    step(7'b0100000);
    step(7'b0000000);
    chk("sat_hold", 0, 16'(stall_cnt), 16'd15);
    chk("sat_fc", 0, 16'(flush_cnt), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_pipe_ctrl.md
Name: cpu_pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MCS8 pipeline (F/D/E/M/W).
- Merges hazard sources into per-stage stall/flush/bubble controls and the PC-source select:
  - data-hazard bubble from cpu_bubble_data
  - branch redirect from E
  - M-stage memory handshake
  - HLT/interrupt
- Sits beside the stage registers; every stage register and the PC mux take their enables from this block only.

Parameters:
- FLUSH_CYCLES, 2, cycles F/D are killed after a taken branch or interrupt redirect (1..7).
- PERF_W, 16, width of saturating stall/flush performance counters.

Ports:
- CLK_I  in  1  clock; all state updates on rising edge.
- RST_I  in  1  synchronous, active-high reset.
- BUBBLE_DATA_I  in  1  RAW hazard from cpu_bubble_data (D source vs E/M dest).
- BRANCH_TAKEN_I  in  1  E-stage jump/call/return resolved taken, qualified by E valid.
- MEM_REQ_I  in  1  M-stage instruction needs the memory bus this cycle.
- MEM_ACK_I  in  1  memory completes the M access this cycle.
- HALT_I  in  1  HLT instruction valid in W.
- INT_REQ_I  in  1  external interrupt (level; only sampled in HALTED or RUN).
- F_STALL_O  out  1  hold PC and F/D register.
- D_STALL_O  out  1  hold D/E register inputs (D stage).
- E_BUBBLE_O  out  1  load NOP (valid=0) into D/E register.
- D_FLUSH_O  out  1  clear F/D register valid.
- M_STALL_O  out  1  hold E/M and M/W registers.
- W_BUBBLE_O  out  1  load valid=0 into W.
- PC_SEL_O  out  2  0 = PC+len, 1 = branch target, 2 = interrupt vector, 3 = reserved (never driven).
- HALTED_O  out  1  core halted.
- STALL_CNT_O  out  PERF_W  cycles with any stall asserted, saturating.
- FLUSH_CNT_O  out  PERF_W  number of redirects, saturating.

Behaviour:
- State register, 2-bit. States: RUN, MEM_WAIT, FLUSH, HALTED. Outputs are Mealy, zero latency: combinational from state and current inputs.
- Reset (RST_I=1 at an edge):
  - state := RUN; flush counter := 0; STALL_CNT_O, FLUSH_CNT_O := 0.
  - While RST_I is high, outputs are forced: D_FLUSH_O=1, E_BUBBLE_O=1, W_BUBBLE_O=1, all stalls 0, PC_SEL_O=0, HALTED_O=0. Reset overrides any mid-operation state.
- RUN, priority order (highest first):
  1. MEM_REQ_I & ~MEM_ACK_I: F_STALL, D_STALL, M_STALL, W_BUBBLE asserted; next state MEM_WAIT. A concurrent branch is held in E, not lost.
  2. HALT_I: W completes; F/D flush and E bubble asserted; next HALTED.
  3. BRANCH_TAKEN_I: PC_SEL_O=1, D_FLUSH, E_BUBBLE; load flush counter with FLUSH_CYCLES-1; next FLUSH if FLUSH_CYCLES>1, else stay RUN.
  4. INT_REQ_I: PC_SEL_O=2, handled as a branch redirect.
  5. BUBBLE_DATA_I: F_STALL, D_STALL, E_BUBBLE; stay RUN.
  6. Otherwise: all controls 0.
- MEM_WAIT:
  - Same freeze outputs as RUN item 1 while ~MEM_ACK_I.
  - On MEM_ACK_I, all controls drop this cycle and next state is RUN. The held branch/bubble is re-evaluated next cycle.
  - BUBBLE_DATA_I and BRANCH_TAKEN_I are ignored in this state.
- FLUSH:
  - D_FLUSH=1, PC_SEL_O=0; counter decrements each cycle; return to RUN when it reaches 0.
  - A MEM stall during FLUSH freezes the counter and asserts the MEM freeze outputs; it does not leave FLUSH.
- HALTED:
  - HALTED_O=1, F_STALL=1, E_BUBBLE=1.
  - INT_REQ_I redirects with PC_SEL_O=2 and goes to FLUSH, or to RUN if FLUSH_CYCLES=1.
- Never assert a stall and a flush on the same register: D_STALL with D_FLUSH is illegal. Flush wins at F/D, and D_STALL is deasserted in that case.
- Counters:
  - STALL_CNT increments when F_STALL_O | M_STALL_O.
  - FLUSH_CNT increments on each PC_SEL_O≠0 cycle.
  - Both saturate at all-ones and do not wrap.

Decomposition:
- Shared package cpu_pipe_pkg: state encodings, PC_SEL codes (PC_SEQ/PC_BR/PC_INT), stage-valid NOP constant.
- One sub-module: cpu_perf_sat_cnt (parameterised saturating counter), instanced twice.

Test Plan:
- Reset: hold RST_I 3 cycles during a branch in FLUSH. Required: D_FLUSH=E_BUBBLE=W_BUBBLE=1 during reset; state RUN and counters 0 after.
- Data hazard: BUBBLE_DATA_I=1 for 2 cycles. Required: F_STALL=D_STALL=E_BUBBLE=1 exactly those 2 cycles, STALL_CNT=2.
- Branch: BRANCH_TAKEN_I pulse, FLUSH_CYCLES=2. Required: PC_SEL=1 and D_FLUSH=1 in cycle 0, D_FLUSH=1 in cycle 1, RUN in cycle 2, FLUSH_CNT=1.
- Memory wait with simultaneous branch: MEM_REQ=1, ACK after 3 cycles, BRANCH_TAKEN_I=1 throughout. Required: M_STALL=1 for 3 cycles, PC_SEL=0 until release, then PC_SEL=1 on the cycle after ACK.
- Halt/interrupt: HALT_I pulse, then INT_REQ_I after 5 cycles. Required: HALTED_O=1 for 5 cycles; PC_SEL=2 on the INT cycle; HALTED_O=0 the next cycle.
- Saturation: PERF_W=4, 20 stall cycles. Required: STALL_CNT=15, no wrap.
